// File: rtl/sys_bus_ctrl_burst_pkg.sv
// Shared bus definitions for the burst bus controller and its slave-side helpers.
// Holds FSM state encoding and default bus geometry.
package sys_bus_ctrl_burst_pkg;

    localparam int STATE_W     = 3;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_OFFS_W  = 8;
    localparam int DEF_IO_NUM  = 2;
    localparam int DEF_WAIT    = 0;
    localparam int DEF_BURST_W = 4;
    localparam int WAIT_W      = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

endpackage

// File: rtl/bus_io_decode.sv
// Slave index decode: one-hot select, out-of-range flag and read-data mux.
// Purely combinational so slave-side arbiters can reuse it.
module bus_io_decode
    import sys_bus_ctrl_burst_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = DEF_ADDR_W - DEF_OFFS_W,
    parameter int IO_NUM = DEF_IO_NUM
) (
    input  logic [IDX_W-1:0]         io_addr,
    input  logic [IO_NUM*DATA_W-1:0] premux,
    output logic [IO_NUM-1:0]        sel,
    output logic                     out_of_range,
    output logic [DATA_W-1:0]        rdata
);

    // One extra bit so IO_NUM == 2**IDX_W is representable.
    localparam logic [IDX_W:0] IO_LIM = (IDX_W+1)'(IO_NUM);

    always_comb begin
        sel          = '0;
        rdata        = '0;
        out_of_range = ({1'b0, io_addr} >= IO_LIM);
        for (int i = 0; i < IO_NUM; i++) begin
            if (io_addr == IDX_W'(i)) begin
                sel[i] = 1'b1;
                rdata  = premux[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/sys_bus_ctrl_burst.sv
// System bus controller: ALE address phase, wait-stated strobes,
// auto-incrementing bursts and error responses for bad requests.
module sys_bus_ctrl_burst
    import sys_bus_ctrl_burst_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int OFFS_W      = DEF_OFFS_W,
    parameter int IO_NUM      = DEF_IO_NUM,
    parameter int WAIT_CYCLES = DEF_WAIT,
    parameter int BURST_W     = DEF_BURST_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ale_en,
    input  logic [ADDR_W-1:0]          addr_input,
    input  logic [BURST_W-1:0]         burst_len,
    input  logic                       bus_read_en,
    input  logic                       bus_write_en,
    input  logic [DATA_W-1:0]          data_write,
    output logic [DATA_W-1:0]          data_read,
    output logic                       bus_ready,
    output logic                       beat_done,
    output logic                       bus_err,
    input  logic [IO_NUM*DATA_W-1:0]   bus_data_read_premux,
    output logic [OFFS_W-1:0]          bus_addr,
    output logic [ADDR_W-OFFS_W-1:0]   io_addr,
    output logic [IO_NUM-1:0]          io_read_en,
    output logic [IO_NUM-1:0]          io_write_en,
    output logic [DATA_W-1:0]          bus_data_write,
    output logic [STATE_W-1:0]         state_now
);

    localparam int              IDX_W     = ADDR_W - OFFS_W;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

    state_t              state;
    state_t              state_nx;
    logic [BURST_W-1:0]  beats;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                dir_wr;
    logic [IO_NUM-1:0]   sel;
    logic                out_of_range;
    logic [DATA_W-1:0]   rdata;
    logic                any_req;

    bus_io_decode #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .IO_NUM (IO_NUM)
    ) u_decode (
        .io_addr      (io_addr),
        .premux       (bus_data_read_premux),
        .sel          (sel),
        .out_of_range (out_of_range),
        .rdata        (rdata)
    );

    assign any_req = bus_read_en | bus_write_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (ale_en) state_nx = ST_ADDR;
            end
            ST_ADDR: begin
                if (ale_en)
                    state_nx = ST_ADDR;
                else if (bus_read_en && bus_write_en)
                    state_nx = ST_ERR;
                else if (any_req && out_of_range)
                    state_nx = ST_ERR;
                else if (any_req)
                    state_nx = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (wait_cnt == '0) state_nx = ST_DONE;
            end
            ST_DONE: begin
                state_nx = (beats != '0) ? ST_ACCESS : ST_IDLE;
            end
            ST_ERR:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_read      <= '0;
            bus_addr       <= '0;
            io_addr        <= '0;
            bus_data_write <= '0;
            beats          <= '0;
            wait_cnt       <= '0;
            dir_wr         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_ADDR: begin
                    if (ale_en) begin
                        {io_addr, bus_addr} <= addr_input;
                        beats               <= burst_len;
                    end else if (state == ST_ADDR) begin
                        // Direction is frozen here for the whole burst.
                        dir_wr   <= bus_write_en;
                        wait_cnt <= WAIT_INIT;
                        if (bus_write_en && !bus_read_en && !out_of_range)
                            bus_data_write <= data_write;
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt == '0) begin
                        if (!dir_wr) data_read <= rdata;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (beats != '0) begin
                        bus_addr <= bus_addr + 1'b1;
                        beats    <= beats - 1'b1;
                        wait_cnt <= WAIT_INIT;
                        if (dir_wr) bus_data_write <= data_write;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_ready   = (state == ST_IDLE);
    assign beat_done   = (state == ST_DONE);
    assign bus_err     = (state == ST_ERR);
    assign io_read_en  = (state == ST_ACCESS && !dir_wr) ? sel : '0;
    assign io_write_en = (state == ST_ACCESS &&  dir_wr) ? sel : '0;
    assign state_now   = state;

endmodule
